// File: rtl/muldiv_unit_if.sv
// EX-stage handshake bundle for muldiv_unit: instruction/operands in, stall/busy/done/result out.
// The pipeline drives the master side; the unit holds the pipeline via combinational stall.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [31:0]     instr;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, instr, op_a, op_b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, instr, op_a, op_b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide: 32-step iterative ops (33 edges accept-to-done); MULDIV_FAST_MUL_EN makes MUL-class single-cycle.
// Divide-by-zero and signed overflow retire on the accept edge; stall holds the pipeline while iterating.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [5:0]        cnt;
  logic [1:0]        fsel;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   ma;
  logic [XLEN-1:0]   mb;
  logic [2*XLEN-1:0] acc;
  logic              busy_r;
  logic              done_r;
  logic [XLEN-1:0]   result_r;

  logic [6:0]      opcode;
  logic [2:0]      f3_in;
  logic [6:0]      f7;
  logic            unused_instr;
  logic            is_m, accept, div_in;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  assign opcode       = bus.instr[6:0];
  assign f3_in        = bus.instr[14:12];
  assign f7           = bus.instr[31:25];
  assign unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};

  assign is_m   = (opcode == 7'b0110011) && (f7 == 7'b0000001);
  assign accept = (state == IDLE) && bus.start && is_m && !bus.flush;
  assign div_in = f3_in[2];

  // MUL treats operands as unsigned: its low product half is sign-agnostic.
  assign a_sgn = div_in ? ~f3_in[0] : ((f3_in[1:0] == 2'b01) || (f3_in[1:0] == 2'b10));
  assign b_sgn = div_in ? ~f3_in[0] : (f3_in[1:0] == 2'b01);
  assign a_neg = a_sgn & bus.op_a[XLEN-1];
  assign b_neg = b_sgn & bus.op_b[XLEN-1];
  assign a_mag = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag = b_neg ? -bus.op_b : bus.op_b;

  assign div_zero = (bus.op_b == '0);
  assign div_ovf  = ~f3_in[0] && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.op_b);

  // Shift-add step: multiplier sits in acc low half and shifts out as product bits shift in.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] mul_fin;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, ma} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc[XLEN-1:1]};
  assign mul_fin  = neg_q ? -mul_next : mul_next;

  // Restoring step: remainder in acc high half, dividend/quotient shifting through the low half.
  logic [XLEN:0]   r_sh;
  logic            div_ge;
  logic [XLEN-1:0] r_new, q_fin, quo_res, rem_res;

  assign r_sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge  = (r_sh >= {1'b0, mb});
  assign r_new   = div_ge ? (r_sh[XLEN-1:0] - mb) : r_sh[XLEN-1:0];
  assign q_fin   = {acc[XLEN-2:0], div_ge};
  assign quo_res = neg_q ? -q_fin : q_fin;
  assign rem_res = neg_r ? -r_new : r_new;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

  assign fast_a    = a_sgn ? {{XLEN{bus.op_a[XLEN-1]}}, bus.op_a} : {{XLEN{1'b0}}, bus.op_a};
  assign fast_b    = b_sgn ? {{XLEN{bus.op_b[XLEN-1]}}, bus.op_b} : {{XLEN{1'b0}}, bus.op_b};
  assign fast_prod = fast_a * fast_b;
`endif

  assign bus.stall  = (state == MUL) || (state == DIV) || accept;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      fsel     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ma       <= '0;
      mb       <= '0;
      acc      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (accept) begin
            fsel  <= f3_in[1:0];
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            ma    <= a_mag;
            mb    <= b_mag;
            cnt   <= '0;
            if (div_in) begin
              if (div_zero) begin
                result_r <= f3_in[1] ? bus.op_a : {XLEN{1'b1}};
                state    <= DONE;
                done_r   <= 1'b1;
              end else if (div_ovf) begin
                result_r <= f3_in[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
                state    <= DONE;
                done_r   <= 1'b1;
              end else begin
                acc    <= {{XLEN{1'b0}}, a_mag};
                state  <= DIV;
                busy_r <= 1'b1;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              result_r <= (f3_in[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
              state    <= DONE;
              done_r   <= 1'b1;
`else
              acc    <= {{XLEN{1'b0}}, b_mag};
              state  <= MUL;
              busy_r <= 1'b1;
`endif
            end
          end
        end
        MUL, DIV: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            acc <= (state == MUL) ? mul_next : {r_new, q_fin};
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              if (state == MUL)
                result_r <= (fsel == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
              else
                result_r <= fsel[1] ? rem_res : quo_res;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, stall/busy/done handshakes, flush and reset aborts.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;

  muldiv_unit_if #(.XLEN(32)) bus ();
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle done is seen (or after the cycle budget).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int lat, output int bad);
    bus.instr = mk_instr(7'b0000001, f3);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    lat = 0;
    bad = 0;
    #1;
    if (bus.stall !== 1'b1) bad++;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!hold) bus.start = 1'b0;
      if (bus.done !== 1'b1 && (bus.stall !== 1'b1 || bus.busy !== 1'b1)) bad++;
    end while (bus.done !== 1'b1 && lat < 60);
  endtask

  task automatic run_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int explat,
                           input bit hold);
    int lat, bad;
    run_op(f3, a, b, hold, lat, bad);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_lat"}, lat, explat);
    check({tag, "_res"}, bus.result, exp);
    check({tag, "_stall_busy_iter"}, bad, 32'd0);
    check({tag, "_stall_busy_done"}, {30'd0, bus.stall, bus.busy}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_pulse_end"}, {31'd0, bus.done}, 32'd0);
    last_res = exp;
  endtask

  task automatic count_done(input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    check({tag, "_extra_done"}, pulses, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.instr = 32'd0;
    bus.op_a  = 32'd0;
    bus.op_b  = 32'd0;
    bus.flush = 1'b0;

    #1 rst = 1'b1;
    #2;
    check("rst_busy",   {31'd0, bus.busy},  32'd0);
    check("rst_done",   {31'd0, bus.done},  32'd0);
    check("rst_result", bus.result,         32'd0);
    check("rst_stall",  {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Divide: signs, magnitudes, and the two early-exit cases
    run_check("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, 1'b0);
    run_check("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, 1'b0);
    run_check("divu_100_7", 3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT, 1'b0);
    run_check("remu_100_7", 3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT, 1'b0);
    run_check("div_100_m7", 3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, DIV_LAT, 1'b0);
    run_check("rem_100_m7", 3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        DIV_LAT, 1'b0);
    run_check("rem_m100_7", 3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, DIV_LAT, 1'b0);
    run_check("divu_by0",   3'b101, 32'h12345678, 32'd0,        32'hFFFFFFFF, 1,       1'b0);
    run_check("remu_by0",   3'b111, 32'h12345678, 32'd0,        32'h12345678, 1,       1'b0);
    run_check("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,       1'b0);
    run_check("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,       1'b0);

    // Multiply: each signedness variant plus low-half MUL
    run_check("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 1'b0);
    run_check("mulhu_ff",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 1'b0);
    run_check("mulhsu_ff",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 1'b0);
    run_check("mulh_m1_5",  3'b001, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, MUL_LAT, 1'b0);
    run_check("mul_m1_2",   3'b000, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, MUL_LAT, 1'b0);

    // Flush mid-divide: back to IDLE, no done, result untouched
    bus.instr = mk_instr(7'b0000001, 3'b101);
    bus.op_a  = 32'd100;
    bus.op_b  = 32'd7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("flush_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy",  {31'd0, bus.busy},  32'd0);
    check("flush_stall", {31'd0, bus.stall}, 32'd0);
    check("flush_done",  {31'd0, bus.done},  32'd0);
    count_done("flush");
    check("flush_result", bus.result, last_res);

    // Non-M ALU op is ignored
    bus.instr = mk_instr(7'b0000000, 3'b000);
    bus.op_a  = 32'd3;
    bus.op_b  = 32'd4;
    bus.start = 1'b1;
    #1;
    check("add_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    check("add_busy", {31'd0, bus.busy}, 32'd0);
    check("add_done", {31'd0, bus.done}, 32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;

    // Reset mid-divide
    bus.instr = mk_instr(7'b0000001, 3'b100);
    bus.op_a  = 32'hFFFFFFF9;
    bus.op_b  = 32'd2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    check("rst_mid_busy_before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy",   {31'd0, bus.busy},  32'd0);
    check("rst_mid_done",   {31'd0, bus.done},  32'd0);
    check("rst_mid_result", bus.result,         32'd0);
    check("rst_mid_stall",  {31'd0, bus.stall}, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Start held high through DONE must not re-accept the retiring instruction
    run_check("mul_3_5_hold", 3'b000, 32'd3, 32'd5, 32'h0000000F, MUL_LAT, 1'b1);
    count_done("mul_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
